// File: rtl/tetris_pkg.sv
// Shared types and keycode constants for the tetris move scheduler and its frame-rate helpers.
package tetris_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    ROTATE = 3'd3,
    DROP   = 3'd4,
    HARD   = 3'd5
  } move_op_t;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_LEFT,
    KEY_RIGHT,
    KEY_ROTATE,
    KEY_SOFT,
    KEY_HARD
  } key_t;

  // ISSUE_* states carry bit 1 so cmd_valid comes straight off a flop.
  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_ISSUE_GRAV = 2'b10,
    S_ISSUE_IN   = 2'b11
  } sched_state_t;

  localparam logic [7:0] KC_A           = 8'h04;
  localparam logic [7:0] KC_LEFT_ARROW  = 8'h50;
  localparam logic [7:0] KC_D           = 8'h07;
  localparam logic [7:0] KC_RIGHT_ARROW = 8'h4F;
  localparam logic [7:0] KC_W           = 8'h1A;
  localparam logic [7:0] KC_UP_ARROW    = 8'h52;
  localparam logic [7:0] KC_S           = 8'h16;
  localparam logic [7:0] KC_DOWN_ARROW  = 8'h51;
  localparam logic [7:0] KC_SPACE       = 8'h2C;

  function automatic key_t decode_key(input logic [7:0] code);
    case (code)
      KC_A, KC_LEFT_ARROW:  decode_key = KEY_LEFT;
      KC_D, KC_RIGHT_ARROW: decode_key = KEY_RIGHT;
      KC_W, KC_UP_ARROW:    decode_key = KEY_ROTATE;
      KC_S, KC_DOWN_ARROW:  decode_key = KEY_SOFT;
      KC_SPACE:             decode_key = KEY_HARD;
      default:              decode_key = KEY_NONE;
    endcase
  endfunction

  // Soft drop only shortens gravity, so it maps to no command of its own.
  function automatic move_op_t key_to_op(input key_t key);
    case (key)
      KEY_LEFT:   key_to_op = LEFT;
      KEY_RIGHT:  key_to_op = RIGHT;
      KEY_ROTATE: key_to_op = ROTATE;
      KEY_HARD:   key_to_op = HARD;
      default:    key_to_op = NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronizes raw vsync into clk and emits a one-cycle tick on its falling edge.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], vsync};
      prev_reg <= sync_reg[1];
    end
  end

  assign tick = prev_reg & ~sync_reg[1];

endmodule

// File: rtl/tetris_move_scheduler.sv
// Turns keycodes and frame gravity into single-step move commands over valid/ready.
// Optional key autorepeat is built when TETRIS_SCHED_DAS_EN is defined.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAV_BASE = 48,
  parameter int GRAV_STEP = 3,
  parameter int GRAV_MIN  = 2
`ifdef TETRIS_SCHED_DAS_EN
  ,
  parameter int DAS_DELAY = 10,
  parameter int DAS_RATE  = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  input  logic [3:0] level,
  input  logic       paused,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  output logic       overrun
);

  sched_state_t state_reg, state_next;
  key_t         key_reg, key_now;
  move_op_t     in_op_reg;
  logic         in_pend_reg, grav_pend_reg, overrun_reg;
  logic [7:0]   grav_cnt_reg;
  logic         tick, step, press, new_in, das_fire;
  logic         xfer, in_clear, grav_clear, hard_clear, grav_due;
  logic [7:0]   lvl_drop, base_period, period;

  frame_tick_gen u_tick (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .tick  (tick)
  );

  assign step    = tick & ~paused;
  assign key_now = decode_key(keycode);
  assign press   = (key_now != KEY_NONE) && (key_now != key_reg);

  // 8-bit period, clamped at GRAV_MIN without wrapping below zero.
  assign lvl_drop    = 8'(level) * 8'(GRAV_STEP);
  assign base_period = (8'(GRAV_BASE) > lvl_drop) ? 8'(GRAV_BASE) - lvl_drop : 8'd0;
  assign period      = (key_now == KEY_SOFT || base_period < 8'(GRAV_MIN)) ? 8'(GRAV_MIN)
                                                                          : base_period;
  assign grav_due    = (grav_cnt_reg + 8'd1) >= period;

  assign xfer       = cmd_valid && cmd_ready;
  assign in_clear   = xfer && (state_reg == S_ISSUE_IN);
  assign grav_clear = xfer && (state_reg == S_ISSUE_GRAV);
  assign hard_clear = in_clear && (in_op_reg == HARD);

`ifdef TETRIS_SCHED_DAS_EN
  logic [7:0] das_cnt_reg, das_inc;
  logic       lr_key, lr_held;

  assign lr_key   = (key_now == KEY_LEFT) || (key_now == KEY_RIGHT);
  assign lr_held  = lr_key && (key_now == key_reg);
  assign das_inc  = das_cnt_reg + 8'd1;
  assign das_fire = step && lr_held && (das_inc == 8'(DAS_DELAY));

  // After the first repeat the count is rewound so it hits DAS_DELAY every DAS_RATE ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      das_cnt_reg <= 8'd0;
    end else if (step) begin
      if (lr_held) das_cnt_reg <= das_fire ? 8'(DAS_DELAY - DAS_RATE) : das_inc;
      else         das_cnt_reg <= lr_key ? 8'd1 : 8'd0;
    end
  end
`else
  assign das_fire = 1'b0;
`endif

  // An edge arriving while the input command is on the bus is dropped so cmd_op stays stable.
  assign new_in = step && ((press && key_to_op(key_now) != NONE) || das_fire) &&
                  (state_reg != S_ISSUE_IN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      key_reg       <= KEY_NONE;
      in_op_reg     <= NONE;
      in_pend_reg   <= 1'b0;
      grav_pend_reg <= 1'b0;
      grav_cnt_reg  <= 8'd0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= 1'b0;
      if (in_clear) in_pend_reg <= 1'b0;
      if (new_in) begin
        in_pend_reg <= 1'b1;
        in_op_reg   <= key_to_op(key_now);
      end
      if (step) key_reg <= key_now;
      if (grav_clear) grav_pend_reg <= 1'b0;
      // Transfer clears first, the tick then re-arms, so an expiry is never lost.
      if (step) begin
        if (grav_due) begin
          grav_cnt_reg  <= 8'd0;
          grav_pend_reg <= 1'b1;
          overrun_reg   <= grav_pend_reg && !grav_clear;
        end else begin
          grav_cnt_reg <= grav_cnt_reg + 8'd1;
        end
      end
      if (hard_clear) begin
        grav_cnt_reg  <= 8'd0;
        grav_pend_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_valid  = state_reg[1];
    cmd_op     = NONE;
    case (state_reg)
      S_IDLE: begin
        if (in_pend_reg)        state_next = S_ISSUE_IN;
        else if (grav_pend_reg) state_next = S_ISSUE_GRAV;
      end
      S_ISSUE_IN: begin
        cmd_op = in_op_reg;
        if (cmd_ready)
          state_next = (grav_pend_reg && in_op_reg != HARD) ? S_ISSUE_GRAV : S_IDLE;
      end
      S_ISSUE_GRAV: begin
        cmd_op = DROP;
        if (cmd_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign overrun = overrun_reg;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler: scoreboard of expected ops popped at each transfer.
module tb_tetris_move_scheduler;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       reset, vsync, paused, cmd_ready, cmd_valid, overrun;
  logic [7:0] keycode;
  logic [3:0] level;
  logic [2:0] cmd_op;

  int checks   = 0;
  int errors   = 0;
  int xfers    = 0;
  int overruns = 0;
  logic [2:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [2:0] prev_op    = 3'd0;

  always #5 clk = ~clk;

  tetris_move_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .keycode   (keycode),
    .level     (level),
    .paused    (paused),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: vsync falls just after a clock edge, 12 cycles total.
  task automatic frame();
    @(posedge clk); #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (7) @(posedge clk);
    #1;
  endtask

  function automatic bit das_hit(input int t);
`ifdef TETRIS_SCHED_DAS_EN
    return (t == 1) || (t >= 10 && ((t - 10) % 3) == 0);
`else
    return t == 1;
`endif
  endfunction

  // Transfer monitor and handshake-stability checks.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (prev_valid && !prev_xfer) begin
        check("hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("hold_op", {29'd0, cmd_op}, {29'd0, prev_op});
      end
      if (overrun) overruns++;
      if (cmd_valid && cmd_ready) begin
        xfers++;
        if (exp_q.size() == 0) check("unexpected_xfer_op", {29'd0, cmd_op}, 32'd0);
        else                   check("xfer_op", {29'd0, cmd_op}, {29'd0, exp_q.pop_front()});
        $display("xfer %0d op=%0d t=%0t", xfers, cmd_op, $time);
      end
      prev_valid = cmd_valid;
      prev_op    = cmd_op;
      prev_xfer  = cmd_valid && cmd_ready;
    end
  end

  initial begin
    int exp_x;
    int p15;
    reset = 1'b1; vsync = 1'b1; keycode = 8'h00; level = 4'd0; paused = 1'b0; cmd_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_op", {29'd0, cmd_op}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    // Level 0 gravity: a single DROP 2 cycles after the 48th tick.
    repeat (47) frame();
    check("t1_none_before", xfers, 0);
    exp_q.push_back(DROP);
    @(posedge clk); #1 vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("t1_valid_early", {31'd0, cmd_valid}, 32'd0);
    @(posedge clk);
    #1 check("t1_valid_2cyc", {31'd0, cmd_valid}, 32'd1);
    check("t1_op", {29'd0, cmd_op}, {29'd0, DROP});
    @(posedge clk); #1 vsync = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("t1_one_drop", xfers, 1);
    check("t1_no_overrun", overruns, 0);

    // LEFT press coinciding with gravity expiry: LEFT wins, DROP follows.
    repeat (47) frame();
    keycode = 8'h50;
    exp_q.push_back(LEFT);
    exp_q.push_back(DROP);
    frame();
    keycode = 8'h00;
    check("t2_xfers", xfers, 3);
    check("t2_queue", exp_q.size(), 0);

    // Stalled consumer at level 15: DROP held, overrun per extra expiry.
    level = 4'd15;
    p15 = (48 - 15 * 3 > 2) ? 48 - 15 * 3 : 2;
    cmd_ready = 1'b0;
    exp_q.push_back(DROP);
    repeat (100) frame();
    check("t3_valid", {31'd0, cmd_valid}, 32'd1);
    check("t3_op", {29'd0, cmd_op}, {29'd0, DROP});
    check("t3_overruns", overruns, 100 / p15 - 1);
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t3_one_drop", xfers, 4);
    check("t3_idle", {31'd0, cmd_valid}, 32'd0);

    // Reset in the middle of a pending ROTATE.
    level = 4'd0;
    cmd_ready = 1'b0;
    keycode = 8'h1A;
    frame();
    keycode = 8'h00;
    check("t5_pre_valid", {31'd0, cmd_valid}, 32'd1);
    check("t5_pre_op", {29'd0, cmd_op}, {29'd0, ROTATE});
    reset = 1'b1;
    @(posedge clk);
    #1 check("t5_rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("t5_rst_op", {29'd0, cmd_op}, 32'd0);
    reset = 1'b0;
    cmd_ready = 1'b1;
    repeat (20) frame();
    check("t5_no_xfer", xfers, 4);

    // HARD at grav_cnt=20 restarts the gravity period.
    keycode = 8'h2C;
    exp_q.push_back(HARD);
    frame();
    keycode = 8'h00;
    check("t4_hard", xfers, 5);
    repeat (47) frame();
    check("t4_no_early_drop", xfers, 5);
    exp_q.push_back(DROP);
    frame();
    check("t4_drop_48", xfers, 6);

    // Paused frames neither sample keys nor advance gravity.
    paused = 1'b1;
    keycode = 8'h04;
    repeat (5) frame();
    check("pause_no_xfer", xfers, 6);
    paused = 1'b0;
    keycode = 8'h00;
    repeat (47) frame();
    check("pause_grav_frozen", xfers, 6);
    exp_q.push_back(DROP);
    frame();
    check("pause_drop", xfers, 7);

    // RIGHT held for 20 ticks.
    exp_x = xfers;
    keycode = 8'h07;
    for (int t = 1; t <= 20; t++) begin
      if (das_hit(t)) begin
        exp_q.push_back(RIGHT);
        exp_x++;
      end
      frame();
      check("das_tick", xfers, exp_x);
    end

    // Soft drop shortens the period to GRAV_MIN; current count 20 fires at once.
    keycode = 8'h16;
    for (int t = 1; t <= 4; t++) begin
      if (t % 2 == 1) begin
        exp_q.push_back(DROP);
        exp_x++;
      end
      frame();
      check("soft_tick", xfers, exp_x);
    end
    keycode = 8'h00;
    frame();

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
